fpu_ss_scoreboard_mp: RTL and testbench
=======================================

Name: fpu_ss_scoreboard_mp

Overview:
Parametrised register/ID scoreboard for the FPU subsystem, replacing the single-bit-per-register scoreboard in the controller. Each FP register has a pending-write counter, so several writes to the same rd can be in flight (optional WAW mode). The block accepts multiple writeback ports, with same-cycle forwarding detection per source operand, and includes a commit-tracking ID table. It sits between the input-buffer pop stage and the FPnew/LSU writeback paths.

Parameters:
NUM_REGS, 32, number of tracked FP registers; REG_W = $clog2(NUM_REGS)
NUM_IDS, 16, number of offload IDs; ID_W = $clog2(NUM_IDS)
NUM_WB, 2, number of writeback ports (port 0 = FPU, port 1 = LSU, higher ports = extra units)
NUM_RS, 3, number of source operands checked
CNT_W, 2, counter width per register; MAXCNT = 2^CNT_W-1
ALLOW_WAW, 1, 1 = multiple outstanding writes per rd allowed; 0 = rd must be idle before issue

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
alloc_valid_i  in  1  issue stage allocates a write to alloc_rd_i
alloc_ready_o  out  1  allocation accepted this cycle
alloc_rd_i  in  REG_W  destination register being allocated
wb_valid_i  in  NUM_WB  writeback to FPR completes this cycle, per port
wb_rd_i  in  NUM_WB*REG_W  writeback register, per port
rs_i  in  NUM_RS*REG_W  source registers of the instruction at buffer head
rs_used_i  in  NUM_RS  operand is an FP register read
dep_rs_o  out  NUM_RS  operand stalled by a pending write
fwd_o  out  NUM_RS*NUM_WB  one-hot forward select per operand
dep_rd_o  out  1  destination hazard; issue must stall
commit_valid_i  in  1  commit interface valid
commit_id_i  in  ID_W  committed ID
commit_kill_i  in  1  kill flag
retire_valid_i  in  NUM_WB  ID retired, per port
retire_id_i  in  NUM_WB*ID_W  retired ID, per port
id_query_i  in  ID_W  ID of the instruction at buffer head
id_ok_o  out  1  queried ID is committed, or is being committed this cycle
pending_o  out  NUM_REGS  per-register counter != 0
err_o  out  1  sticky underflow/overflow error

Behaviour:
- Reset: synchronous, active-low. All counters = 0, ID table = 0, err_o = 0. Hence pending_o = 0, dep_* = 0, fwd_o = 0, id_ok_o = 0, alloc_ready_o = 1. Reset asserted mid-operation discards every in-flight count with no drain.
- hits[r] = number of ports p with wb_valid_i[p] and wb_rd_i[p] == r (0..NUM_WB).
- last[r] = cnt[r] != 0 and hits[r] == cnt[r]. This marks the writeback(s) that clear the register.
- Counter update, registered at the next edge: cnt_d[r] = cnt[r] + (alloc hs and alloc_rd_i == r) - hits[r]. Alloc and writeback to the same register in the same cycle: net change computed, no double count.
- Underflow (hits[r] > cnt[r] plus increment): counter clamps to 0 and err_o sets. err_o clears only on reset.
- alloc_ready_o = cnt[alloc_rd_i] < MAXCNT, or hits[alloc_rd_i] >= 1. Same-cycle release is honoured. alloc hs = alloc_valid_i & alloc_ready_o.
- fwd_o[i][p] = 1 for the lowest-index p with wb_valid_i[p], wb_rd_i[p] == rs_i[i], rs_used_i[i] and last[rs_i[i]]. Forwarding happens only from the final outstanding write; an older write must not be forwarded.
- dep_rs_o[i] = rs_used_i[i] & cnt[rs_i[i]] != 0 & ~|fwd_o[i].
- dep_rd_o:
  - ALLOW_WAW = 0: alloc_valid_i & cnt[alloc_rd_i] != 0 & ~last[alloc_rd_i].
  - ALLOW_WAW = 1: alloc_valid_i & ~alloc_ready_o.
- alloc_ready_o is additionally gated by ~dep_rd_o.
- ID table:
  - commit_valid_i & ~commit_kill_i sets bit commit_id_i.
  - Each retire_valid_i[p] clears bit retire_id_i[p].
  - Commit and retire to the same ID in the same cycle: commit wins.
  - A killed commit changes nothing.
- id_ok_o = tbl[id_query_i] | (commit_valid_i & ~commit_kill_i & commit_id_i == id_query_i). Zero-latency bypass.
- Retiring an ID whose bit is 0 sets err_o.
- All outputs except err_o are combinational from state and same-cycle inputs. State latency is 1 cycle.

Test Plan:
- Reset, then release: pending_o = 0, alloc_ready_o = 1, err_o = 0. Allocate rd = 5 -> next cycle pending_o[5] = 1; rs_i[0] = 5 used -> dep_rs_o[0] = 1.
- ALLOW_WAW = 1, CNT_W = 2: allocate rd = 3 three times -> cnt = 3, fourth allocation gets alloc_ready_o = 0. Fourth allocation with wb port 0 to rd = 3 in the same cycle -> accepted, cnt stays 3.
- cnt[7] = 2, wb port 0 to rd = 7, rs0 = 7 -> fwd_o[0] = 0, dep_rs_o[0] = 1. Next cycle, wb port 1 to rd = 7 -> fwd_o[0] = 2'b10, dep_rs_o[0] = 0, cnt = 0 after the edge.
- cnt[9] = 2, both ports write rd = 9 in the same cycle -> fwd_o selects port 0, cnt = 0. Repeat with cnt[9] = 1 -> err_o = 1, cnt clamps to 0.
- ALLOW_WAW = 0: cnt[4] = 1, allocate rd = 4 -> dep_rd_o = 1, alloc_ready_o = 0. Same with wb to rd = 4 in that cycle -> dep_rd_o = 0, accepted, cnt = 1.
- ID table:
  - Commit id = 6 and query 6 in the same cycle -> id_ok_o = 1; next cycle id_ok_o stays 1.
  - Killed commit of id = 8 -> id_ok_o = 0.
  - Commit and retire of id = 6 in the same cycle -> bit stays 1.

Source files
------------

// File: rtl/fpu_ss_scoreboard_mp.sv
`default_nettype none
// ============================================================================
// Module   : fpu_ss_scoreboard_mp
// Brief    : FP register scoreboard with per-register pending-write counters,
//            multi-port writeback, last-write forwarding detection and an
//            offload-ID commit table.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_ss_scoreboard_mp #(
    parameter int NUM_REGS  = 32,
    parameter int NUM_IDS   = 16,
    parameter int NUM_WB    = 2,
    parameter int NUM_RS    = 3,
    parameter int CNT_W     = 2,
    parameter int ALLOW_WAW = 1,
    parameter int REG_W     = $clog2(NUM_REGS),
    parameter int ID_W      = $clog2(NUM_IDS)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       alloc_valid_i,
    output logic                       alloc_ready_o,
    input  logic [REG_W-1:0]           alloc_rd_i,
    input  logic [NUM_WB-1:0]          wb_valid_i,
    input  logic [NUM_WB*REG_W-1:0]    wb_rd_i,
    input  logic [NUM_RS*REG_W-1:0]    rs_i,
    input  logic [NUM_RS-1:0]          rs_used_i,
    output logic [NUM_RS-1:0]          dep_rs_o,
    output logic [NUM_RS*NUM_WB-1:0]   fwd_o,
    output logic                       dep_rd_o,
    input  logic                       commit_valid_i,
    input  logic [ID_W-1:0]            commit_id_i,
    input  logic                       commit_kill_i,
    input  logic [NUM_WB-1:0]          retire_valid_i,
    input  logic [NUM_WB*ID_W-1:0]     retire_id_i,
    input  logic [ID_W-1:0]            id_query_i,
    output logic                       id_ok_o,
    output logic [NUM_REGS-1:0]        pending_o,
    output logic                       err_o
);

    localparam int HIT_W = $clog2(NUM_WB + 1);
    // Wide enough to hold cnt + 1 and the hit count without wrapping
    localparam int SUM_W = ((CNT_W > HIT_W) ? CNT_W : HIT_W) + 1;
    localparam logic [SUM_W-1:0] MAXCNT = SUM_W'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] r_cnt [NUM_REGS];
    logic [NUM_IDS-1:0] r_tbl;
    logic               r_err;

    logic [HIT_W-1:0]   w_hits [NUM_REGS];
    logic [NUM_REGS-1:0] w_last;
    logic [CNT_W-1:0]   w_cnt_d [NUM_REGS];
    logic               w_err_cnt;
    logic [NUM_IDS-1:0] w_tbl_d;
    logic               w_err_id;
    logic               w_room;
    logic               w_alloc_hs;

    // Per-register writeback hit count and "this writeback drains it" flag
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_hits[r] = '0;
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid_i[p] && (wb_rd_i[p*REG_W +: REG_W] == REG_W'(r)))
                    w_hits[r] = w_hits[r] + HIT_W'(1);
            end
            w_last[r] = (r_cnt[r] != '0) && (SUM_W'(w_hits[r]) == SUM_W'(r_cnt[r]));
        end
    end

    // Allocation handshake; a same-cycle release frees a saturated counter
    always_comb begin
        w_room = (SUM_W'(r_cnt[alloc_rd_i]) < MAXCNT) || (w_hits[alloc_rd_i] != '0);
        if (ALLOW_WAW != 0)
            dep_rd_o = alloc_valid_i & ~w_room;
        else
            dep_rd_o = alloc_valid_i & (r_cnt[alloc_rd_i] != '0) & ~w_last[alloc_rd_i];
        alloc_ready_o = w_room & ~dep_rd_o;
        w_alloc_hs    = alloc_valid_i & alloc_ready_o;
    end

    // Next counter values: net of allocation and writebacks, clamped on underflow
    always_comb begin
        w_err_cnt = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            logic [SUM_W-1:0] w_sum;
            logic [SUM_W-1:0] w_diff;
            w_sum  = SUM_W'(r_cnt[r]) + SUM_W'(w_alloc_hs && (alloc_rd_i == REG_W'(r)));
            w_diff = w_sum - SUM_W'(w_hits[r]);
            if (SUM_W'(w_hits[r]) > w_sum) begin
                w_cnt_d[r] = '0;
                w_err_cnt  = 1'b1;
            end else if (w_diff > MAXCNT) begin
                w_cnt_d[r] = MAXCNT[CNT_W-1:0];
                w_err_cnt  = 1'b1;
            end else begin
                w_cnt_d[r] = w_diff[CNT_W-1:0];
            end
        end
    end

    // Operand hazards; only the final outstanding write may be forwarded
    always_comb begin
        fwd_o    = '0;
        dep_rs_o = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            logic [REG_W-1:0] w_rs;
            logic             w_found;
            w_rs    = rs_i[i*REG_W +: REG_W];
            w_found = 1'b0;
            for (int p = 0; p < NUM_WB; p++) begin
                if (!w_found && wb_valid_i[p] && (wb_rd_i[p*REG_W +: REG_W] == w_rs) &&
                    rs_used_i[i] && w_last[w_rs]) begin
                    fwd_o[i*NUM_WB + p] = 1'b1;
                    w_found             = 1'b1;
                end
            end
            dep_rs_o[i] = rs_used_i[i] && (r_cnt[w_rs] != '0) && !w_found;
        end
    end

    // ID table update: retires clear, a live commit sets and wins over retire
    always_comb begin
        w_tbl_d  = r_tbl;
        w_err_id = 1'b0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (retire_valid_i[p]) begin
                if (!r_tbl[retire_id_i[p*ID_W +: ID_W]])
                    w_err_id = 1'b1;
                w_tbl_d[retire_id_i[p*ID_W +: ID_W]] = 1'b0;
            end
        end
        if (commit_valid_i && !commit_kill_i)
            w_tbl_d[commit_id_i] = 1'b1;
    end

    // Query result with zero-latency bypass of the current commit
    always_comb begin
        id_ok_o = r_tbl[id_query_i] |
                  (commit_valid_i & ~commit_kill_i & (commit_id_i == id_query_i));
        for (int r = 0; r < NUM_REGS; r++)
            pending_o[r] = (r_cnt[r] != '0);
    end

    assign err_o = r_err;

    // State registers; reset drops all in-flight counts immediately
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_REGS; r++)
                r_cnt[r] <= '0;
            r_tbl <= '0;
            r_err <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                r_cnt[r] <= w_cnt_d[r];
            r_tbl <= w_tbl_d;
            r_err <= r_err | w_err_cnt | w_err_id;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_ss_scoreboard_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_ss_scoreboard_mp
// Brief    : Directed vector bench for fpu_ss_scoreboard_mp (WAW and no-WAW).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_ss_scoreboard_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_rd;
    logic [14:0] rs;
    logic [2:0]  rs_used;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic        commit_kill;
    logic [1:0]  retire_valid;
    logic [7:0]  retire_id;
    logic [3:0]  id_query;

    logic        ready1, deprd1, idok1, err1;
    logic [2:0]  deprs1;
    logic [5:0]  fwd1;
    logic [31:0] pend1;
    logic        ready0, deprd0, idok0, err0;
    logic [2:0]  deprs0;
    logic [5:0]  fwd0;
    logic [31:0] pend0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpu_ss_scoreboard_mp #(.ALLOW_WAW(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(ready1), .alloc_rd_i(alloc_rd),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
        .rs_i(rs), .rs_used_i(rs_used), .dep_rs_o(deprs1), .fwd_o(fwd1), .dep_rd_o(deprd1),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .retire_valid_i(retire_valid), .retire_id_i(retire_id),
        .id_query_i(id_query), .id_ok_o(idok1), .pending_o(pend1), .err_o(err1)
    );

    fpu_ss_scoreboard_mp #(.ALLOW_WAW(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(ready0), .alloc_rd_i(alloc_rd),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
        .rs_i(rs), .rs_used_i(rs_used), .dep_rs_o(deprs0), .fwd_o(fwd0), .dep_rd_o(deprd0),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .retire_valid_i(retire_valid), .retire_id_i(retire_id),
        .id_query_i(id_query), .id_ok_o(idok0), .pending_o(pend0), .err_o(err0)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [1:0]  wbv;
        logic [4:0]  wr0;
        logic [4:0]  wr1;
        logic [4:0]  rs0;
        logic        use0;
        logic        e_ready;
        logic        e_deprd;
        logic        e_dep0;
        logic [1:0]  e_fwd0;
        logic [31:0] e_pend;
        logic        e_err;
    } vec_t;

    vec_t vt [24];

    function automatic vec_t mk(logic av, logic [4:0] ard, logic [1:0] wbv,
                                logic [4:0] wr0, logic [4:0] wr1, logic [4:0] rs0,
                                logic use0, logic e_ready, logic e_deprd, logic e_dep0,
                                logic [1:0] e_fwd0, logic [31:0] e_pend, logic e_err);
        vec_t v;
        v.av = av; v.ard = ard; v.wbv = wbv; v.wr0 = wr0; v.wr1 = wr1;
        v.rs0 = rs0; v.use0 = use0; v.e_ready = e_ready; v.e_deprd = e_deprd;
        v.e_dep0 = e_dep0; v.e_fwd0 = e_fwd0; v.e_pend = e_pend; v.e_err = e_err;
        return v;
    endfunction

    function automatic logic [31:0] bit_of(int n);
        logic [31:0] one;
        one = 32'd1;
        return one << n;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_valid = 0; alloc_rd = 0; wb_valid = 0; wb_rd = 0;
        rs = 0; rs_used = 0; commit_valid = 0; commit_id = 0; commit_kill = 0;
        retire_valid = 0; retire_id = 0; id_query = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        vt[0]  = mk(0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 32'd0,     0);
        vt[1]  = mk(1, 5, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 32'd0,     0);
        vt[2]  = mk(0, 0, 2'd0, 0, 0, 5, 1, 1, 0, 1, 2'd0, bit_of(5), 0);
        vt[3]  = mk(0, 0, 2'd1, 5, 0, 5, 1, 1, 0, 0, 2'd1, bit_of(5), 0);
        vt[4]  = mk(1, 3, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 32'd0,     0);
        vt[5]  = mk(1, 3, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2'd0, bit_of(3), 0);
        vt[6]  = mk(1, 3, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2'd0, bit_of(3), 0);
        vt[7]  = mk(1, 3, 2'd0, 0, 0, 0, 0, 0, 1, 0, 2'd0, bit_of(3), 0);
        vt[8]  = mk(1, 3, 2'd1, 3, 0, 0, 0, 1, 0, 0, 2'd0, bit_of(3), 0);
        vt[9]  = mk(0, 0, 2'd3, 3, 3, 3, 1, 1, 0, 1, 2'd0, bit_of(3), 0);
        vt[10] = mk(0, 0, 2'd2, 0, 3, 3, 1, 1, 0, 0, 2'd2, bit_of(3), 0);
        vt[11] = mk(0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 32'd0,     0);
        vt[12] = mk(1, 7, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 32'd0,     0);
        vt[13] = mk(1, 7, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2'd0, bit_of(7), 0);
        vt[14] = mk(0, 0, 2'd1, 7, 0, 7, 1, 1, 0, 1, 2'd0, bit_of(7), 0);
        vt[15] = mk(0, 0, 2'd2, 0, 7, 7, 1, 1, 0, 0, 2'd2, bit_of(7), 0);
        vt[16] = mk(0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 32'd0,     0);
        vt[17] = mk(1, 9, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 32'd0,     0);
        vt[18] = mk(1, 9, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2'd0, bit_of(9), 0);
        vt[19] = mk(0, 0, 2'd3, 9, 9, 9, 1, 1, 0, 0, 2'd1, bit_of(9), 0);
        vt[20] = mk(0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 32'd0,     0);
        vt[21] = mk(1, 9, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 32'd0,     0);
        vt[22] = mk(0, 0, 2'd3, 9, 9, 9, 1, 1, 0, 1, 2'd0, bit_of(9), 0);
        vt[23] = mk(0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 32'd0,     1);

        do_reset();

        // Table: WAW-enabled instance, one record per cycle
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            alloc_valid = vt[k].av;
            alloc_rd    = vt[k].ard;
            wb_valid    = vt[k].wbv;
            wb_rd       = {vt[k].wr1, vt[k].wr0};
            rs          = {10'd0, vt[k].rs0};
            rs_used     = {2'b00, vt[k].use0};
            #1;
            chk($sformatf("v%0d ready", k), 32'(ready1),     32'(vt[k].e_ready));
            chk($sformatf("v%0d dep_rd", k), 32'(deprd1),    32'(vt[k].e_deprd));
            chk($sformatf("v%0d dep_rs0", k), 32'(deprs1[0]), 32'(vt[k].e_dep0));
            chk($sformatf("v%0d fwd0", k), 32'(fwd1[1:0]),   32'(vt[k].e_fwd0));
            chk($sformatf("v%0d pending", k), pend1,          vt[k].e_pend);
            chk($sformatf("v%0d err", k), 32'(err1),          32'(vt[k].e_err));
        end

        // Reset clears the sticky error and all state
        do_reset();
        @(negedge clk);
        idle_inputs();
        #1;
        chk("rst err1", 32'(err1), 32'd0);
        chk("rst pend1", pend1, 32'd0);
        chk("rst pend0", pend0, 32'd0);
        chk("rst ready0", 32'(ready0), 32'd1);
        chk("rst idok1", 32'(idok1), 32'd0);
        chk("rst fwd1", 32'(fwd1), 32'd0);
        chk("rst deprs1", 32'(deprs1), 32'd0);

        // No-WAW instance: rd busy blocks, unless drained this cycle
        alloc_valid = 1; alloc_rd = 4;
        #1;
        chk("nowaw first ready", 32'(ready0), 32'd1);
        @(negedge clk);
        #1;
        chk("nowaw busy dep_rd", 32'(deprd0), 32'd1);
        chk("nowaw busy ready", 32'(ready0), 32'd0);
        chk("nowaw busy pend", pend0, bit_of(4));
        @(negedge clk);
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd4};
        #1;
        chk("nowaw drain dep_rd", 32'(deprd0), 32'd0);
        chk("nowaw drain ready", 32'(ready0), 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("nowaw after pend", pend0, bit_of(4));
        chk("nowaw err", 32'(err0), 32'd0);

        // Mid-operation reset drops in-flight counts
        do_reset();
        @(negedge clk);
        #1;
        chk("midrst pend0", pend0, 32'd0);
        chk("midrst pend1", pend1, 32'd0);

        // ID table
        commit_valid = 1; commit_id = 6; id_query = 6;
        #1;
        chk("id commit bypass", 32'(idok1), 32'd1);
        @(negedge clk);
        idle_inputs(); id_query = 6;
        #1;
        chk("id committed", 32'(idok1), 32'd1);
        @(negedge clk);
        commit_valid = 1; commit_kill = 1; commit_id = 8; id_query = 8;
        #1;
        chk("id killed bypass", 32'(idok1), 32'd0);
        @(negedge clk);
        idle_inputs(); id_query = 8;
        #1;
        chk("id killed stays", 32'(idok1), 32'd0);
        @(negedge clk);
        commit_valid = 1; commit_id = 6; retire_valid = 2'b01; retire_id = {4'd0, 4'd6};
        @(negedge clk);
        idle_inputs(); id_query = 6;
        #1;
        chk("id commit wins", 32'(idok1), 32'd1);
        chk("id no err", 32'(err1), 32'd0);
        retire_valid = 2'b10; retire_id = {4'd6, 4'd0};
        @(negedge clk);
        idle_inputs(); id_query = 6;
        #1;
        chk("id retired", 32'(idok1), 32'd0);
        chk("id retire err0", 32'(err1), 32'd0);
        retire_valid = 2'b01; retire_id = {4'd0, 4'd6};
        @(negedge clk);
        idle_inputs();
        #1;
        chk("id double retire err", 32'(err1), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
